dmem_wb_responder: RTL and testbench
====================================

Name: dmem_wb_responder

Overview:
- Wishbone-classic data-memory responder: the memory-side end of the load-store unit's bus.
- Accepts single read/write requests from the LSU master and performs byte-lane-masked writes into an internal word array.
- Returns read data with a single-cycle ack after a programmable number of wait states.
- Flags out-of-range or empty-select requests with err instead of ack. Replaces the bare BRAM model in LSU simulations and FPGA builds.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two.
- LATENCY, 1, wait states between request sampling and response; range 0..15.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- wbs_cyc_i  input  1  bus cycle valid.
- wbs_stb_i  input  1  strobe; a request is valid when cyc=1 and stb=1.
- wbs_we_i  input  1  1 = write, 0 = read.
- wbs_addr_i  input  32  byte address; bits [1:0] ignored.
- wbs_dat_i  input  32  write data.
- wbs_sel_i  input  4  byte-lane enables; bit n selects dat[8n+7:8n].
- wbs_dat_o  output  32  read data.
- wbs_ack_o  output  1  one-cycle successful completion.
- wbs_err_o  output  1  one-cycle error completion.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; ack=0, err=0, dat_o=0; wait counter=0.
  - Memory contents are not cleared and are retained across reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a clock edge with cyc&stb=1, latch addr, dat, sel and we.
  - Compute bad = (addr >= 4*DEPTH) or (sel==0).
  - If LATENCY=0, go to RESP; otherwise load counter=LATENCY-1 and go to WAIT.
- WAIT: decrement the counter each cycle; go to RESP when counter=0.
- RESP:
  - Drive exactly one of ack/err high for one cycle, then return to IDLE.
  - Response appears LATENCY+1 edges after the request edge; with LATENCY=1, ack is high on the 2nd cycle after stb is first sampled.
  - Good write: on the edge entering RESP, write only the selected byte lanes of mem[addr[log2(DEPTH)+1:2]]; unselected lanes are unchanged. dat_o is unchanged.
  - Good read: dat_o = full 32-bit word, registered on the edge entering RESP. It is valid with ack and holds until the next good read or reset. sel does not mask read data.
  - Bad request: err=1, ack=0, no memory write, dat_o=0.
- Inputs are only latched in IDLE; changes to addr/dat/sel/we during WAIT/RESP are ignored.
- Abort: if cyc=0 is sampled in WAIT, or on the edge entering RESP, go to IDLE with no ack/err and no write.
- Throughput: new requests are sampled only in IDLE. The earliest back-to-back request edge is the cycle after RESP, giving one transaction per LATENCY+2 cycles.
- Master holding stb high after ack is treated as a new request in IDLE (classic Wishbone).
- ack and err are never high simultaneously, and never high for two consecutive cycles.
- Reset asserted mid-transaction: the transaction is dropped immediately, with no ack/err. A write whose RESP edge has not occurred is not performed.

Test Plan:
- Reset: hold rst=0 for 5 cycles with stb toggling -> ack=0, err=0, dat_o=0 throughout. Release; 3 idle cycles -> no response.
- Word write then read, LATENCY=1:
  - Write addr=0x0, dat=0x00000007, sel=0xF -> ack exactly 2 cycles after request, one cycle wide.
  - Read addr=0x0 -> ack with dat_o=0x00000007.
- Byte-lane write:
  - Preload addr=0x10 with 0xAABBCCDD.
  - Write dat=0x11223344, sel=0b0101 -> read back 0xAA22CC44.
- Error paths:
  - Read addr=4*DEPTH (0x1000 at default) -> err one cycle, ack=0, dat_o=0.
  - Write sel=0 to addr=0x4 -> err; subsequent read of 0x4 returns the prior value.
- Abort and reset mid-op, LATENCY=3:
  - Start write 0xDEADBEEF to 0x8; drop cyc in WAIT -> no ack; read 0x8 returns the old value.
  - Repeat with rst pulsed low in WAIT -> same result, outputs cleared asynchronously.
- Back-to-back, LATENCY=0: stb held high with 4 reads to 0x0,0x4,0x8,0xC -> acks every 2nd cycle with matching data, never two consecutive ack cycles.

Source files
------------

// File: rtl/dmem_wb_responder.sv
// dmem_wb_responder: Wishbone-classic data memory with byte-lane writes, programmable wait states and err on bad requests
module dmem_wb_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT0 = LATENCY == 0 ? 4'd0 : 4'(LATENCY - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state;
  logic [3:0]  cnt, sel_q, s;
  logic [29:0] addr_q, a;
  logic [31:0] dat_q, d;
  logic        we_q, w, go, bad, unused_ok;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];
  // With zero wait states the request edge is also the RESP edge, so act on the live bus
  assign a   = state == IDLE ? wbs_addr_i[31:2] : addr_q;
  assign d   = state == IDLE ? wbs_dat_i : dat_q;
  assign s   = state == IDLE ? wbs_sel_i : sel_q;
  assign w   = state == IDLE ? wbs_we_i : we_q;
  assign bad = (a >> AW) != 30'd0 || s == 4'd0;
  assign idx = a[AW-1:0];
  assign go  = state == IDLE ? wbs_cyc_i && wbs_stb_i && LATENCY == 0
                             : state == WAIT && cnt == 4'd0 && wbs_cyc_i;
  assign unused_ok = &{1'b0, wbs_addr_i[1:0]};
  // Memory sits outside the reset branch: contents survive reset, writes are suppressed while it is held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      addr_q    <= 30'd0;
      dat_q     <= 32'd0;
      sel_q     <= 4'd0;
      we_q      <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      wbs_ack_o <= go && !bad;
      wbs_err_o <= go && bad;
      if (go) wbs_dat_o <= bad ? 32'd0 : w ? wbs_dat_o : mem[idx];
      if (go && !bad && w)
        for (int i = 0; i < 4; i++)
          if (s[i]) mem[idx][8*i +: 8] <= d[8*i +: 8];
      case (state)
        IDLE: if (wbs_cyc_i && wbs_stb_i) begin
          addr_q <= wbs_addr_i[31:2];
          dat_q  <= wbs_dat_i;
          sel_q  <= wbs_sel_i;
          we_q   <= wbs_we_i;
          cnt    <= CNT0;
          state  <= LATENCY == 0 ? RESP : WAIT;
        end
        WAIT: begin
          cnt   <= cnt - 4'd1;
          state <= !wbs_cyc_i ? IDLE : cnt == 4'd0 ? RESP : WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_wb_responder.sv
// tb_dmem_wb_responder: three responders (LATENCY 1, 3, 0) checked against a word-array reference model
module tb_dmem_wb_responder;
  localparam int DEPTH = 1024;
  logic        clk = 1'b0, rst = 1'b0;
  logic [2:0]  cyc, stb, we, ack, err;
  logic [31:0] addr [3], wdat [3], rdat [3];
  logic [3:0]  sel [3];
  logic [31:0] mdl [3][DEPTH];
  logic [31:0] last [3];
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  dmem_wb_responder #(.DEPTH(DEPTH), .LATENCY(1)) u0 (.clk(clk), .rst(rst), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]),
    .wbs_we_i(we[0]), .wbs_addr_i(addr[0]), .wbs_dat_i(wdat[0]), .wbs_sel_i(sel[0]), .wbs_dat_o(rdat[0]),
    .wbs_ack_o(ack[0]), .wbs_err_o(err[0]));
  dmem_wb_responder #(.DEPTH(DEPTH), .LATENCY(3)) u1 (.clk(clk), .rst(rst), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]),
    .wbs_we_i(we[1]), .wbs_addr_i(addr[1]), .wbs_dat_i(wdat[1]), .wbs_sel_i(sel[1]), .wbs_dat_o(rdat[1]),
    .wbs_ack_o(ack[1]), .wbs_err_o(err[1]));
  dmem_wb_responder #(.DEPTH(DEPTH), .LATENCY(0)) u2 (.clk(clk), .rst(rst), .wbs_cyc_i(cyc[2]), .wbs_stb_i(stb[2]),
    .wbs_we_i(we[2]), .wbs_addr_i(addr[2]), .wbs_dat_i(wdat[2]), .wbs_sel_i(sel[2]), .wbs_dat_o(rdat[2]),
    .wbs_ack_o(ack[2]), .wbs_err_o(err[2]));

  function automatic int lat_of(input int k);
    return k == 0 ? 1 : k == 1 ? 3 : 0;
  endfunction

  // Reference: a request is bad when its byte address is beyond the array or no lane is selected
  function automatic void mdl_txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] s, output logic bad, output logic [31:0] rd);
    int ix;
    bad = a >= 32'(4 * DEPTH) || s == 4'd0;
    ix = bad ? 0 : int'(a[31:2]);
    if (bad) last[k] = 32'd0;
    else if (w) begin
      for (int i = 0; i < 4; i++) if (s[i]) mdl[k][ix][8*i +: 8] = d[8*i +: 8];
    end else last[k] = mdl[k][ix];
    rd = last[k];
  endfunction

  task automatic do_txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output int n, output logic got_ack, output logic got_err, output logic extra,
                        output logic [31:0] got_dat);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; addr[k] = a; wdat[k] = d; sel[k] = s;
    n = 0; got_ack = 1'b0; got_err = 1'b0;
    while (n < 20 && !got_ack && !got_err) begin
      @(posedge clk); @(negedge clk);
      n++;
      got_ack = ack[k]; got_err = err[k];
    end
    got_dat = rdat[k];
    cyc[k] = 1'b0; stb[k] = 1'b0;
    @(posedge clk); @(negedge clk);
    extra = ack[k] | err[k];
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc[0] = 1'b1; stb[0] = i[0]; we[0] = 1'b0; addr[0] = 32'h0; sel[0] = 4'hF;
      @(posedge clk); @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        total++;
        if ({ack[k], err[k], rdat[k]} !== 34'd0)
          $display("FAIL reset_hold dut%0d: ack=%b err=%b dat=%h, required 0/0/0", k, ack[k], err[k], rdat[k]);
        else passed++;
      end
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) last[k] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if ((ack | err) !== 3'b0) $display("FAIL reset_idle: ack=%b err=%b, required none", ack, err);
      else passed++;
    end
  endtask

  task automatic test_word_rw();
    int n; logic ga, ge, x, bad; logic [31:0] gd, ed;
    do_txn(0, 1'b1, 32'h0, 32'h7, 4'hF, n, ga, ge, x, gd);
    mdl_txn(0, 1'b1, 32'h0, 32'h7, 4'hF, bad, ed);
    total++;
    if (n !== 2 || ga !== 1'b1 || ge !== 1'b0 || x !== 1'b0)
      $display("FAIL word_write: cycles=%0d ack=%b err=%b extra=%b, required 2/1/0/0", n, ga, ge, x);
    else passed++;
    do_txn(0, 1'b0, 32'h0, 32'h0, 4'hF, n, ga, ge, x, gd);
    mdl_txn(0, 1'b0, 32'h0, 32'h0, 4'hF, bad, ed);
    total++;
    if (n !== 2 || ga !== 1'b1 || x !== 1'b0 || gd !== ed)
      $display("FAIL word_read: cycles=%0d ack=%b extra=%b dat=%h, required 2/1/0/%h", n, ga, x, gd, ed);
    else passed++;
  endtask

  task automatic test_byte_lane();
    int n; logic ga, ge, x, bad; logic [31:0] gd, ed;
    do_txn(0, 1'b1, 32'h10, 32'hAABBCCDD, 4'hF, n, ga, ge, x, gd);
    mdl_txn(0, 1'b1, 32'h10, 32'hAABBCCDD, 4'hF, bad, ed);
    do_txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, n, ga, ge, x, gd);
    mdl_txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, bad, ed);
    total++;
    if (ga !== 1'b1 || gd !== ed) $display("FAIL lane_write: ack=%b dat=%h, required 1/%h", ga, gd, ed);
    else passed++;
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'b0001, n, ga, ge, x, gd);
    mdl_txn(0, 1'b0, 32'h10, 32'h0, 4'b0001, bad, ed);
    total++;
    if (ga !== 1'b1 || gd !== ed || gd !== 32'hAA22CC44)
      $display("FAIL lane_read: ack=%b dat=%h, required 1/%h", ga, gd, ed);
    else passed++;
  endtask

  task automatic test_errors();
    int n; logic ga, ge, x, bad; logic [31:0] gd, ed;
    do_txn(0, 1'b0, 32'(4 * DEPTH), 32'h0, 4'hF, n, ga, ge, x, gd);
    mdl_txn(0, 1'b0, 32'(4 * DEPTH), 32'h0, 4'hF, bad, ed);
    total++;
    if (n !== 2 || ga !== 1'b0 || ge !== 1'b1 || x !== 1'b0 || gd !== ed)
      $display("FAIL err_range: cycles=%0d ack=%b err=%b extra=%b dat=%h, required 2/0/1/0/%h", n, ga, ge, x, gd, ed);
    else passed++;
    do_txn(0, 1'b1, 32'h4, 32'h55AA55AA, 4'hF, n, ga, ge, x, gd);
    mdl_txn(0, 1'b1, 32'h4, 32'h55AA55AA, 4'hF, bad, ed);
    do_txn(0, 1'b1, 32'h4, 32'hFFFFFFFF, 4'h0, n, ga, ge, x, gd);
    mdl_txn(0, 1'b1, 32'h4, 32'hFFFFFFFF, 4'h0, bad, ed);
    total++;
    if (ga !== 1'b0 || ge !== 1'b1 || x !== 1'b0) $display("FAIL err_sel0: ack=%b err=%b extra=%b, required 0/1/0", ga, ge, x);
    else passed++;
    do_txn(0, 1'b0, 32'h4, 32'h0, 4'hF, n, ga, ge, x, gd);
    mdl_txn(0, 1'b0, 32'h4, 32'h0, 4'hF, bad, ed);
    total++;
    if (ga !== 1'b1 || gd !== ed) $display("FAIL err_sel0_keep: ack=%b dat=%h, required 1/%h", ga, gd, ed);
    else passed++;
  endtask

  task automatic start_write8();
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h8; wdat[1] = 32'hDEADBEEF; sel[1] = 4'hF;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_abort();
    int n; logic ga, ge, x, bad, seen; logic [31:0] gd, ed;
    do_txn(1, 1'b1, 32'h8, 32'h12345678, 4'hF, n, ga, ge, x, gd);
    mdl_txn(1, 1'b1, 32'h8, 32'h12345678, 4'hF, bad, ed);
    do_txn(1, 1'b0, 32'h8, 32'h0, 4'hF, n, ga, ge, x, gd);
    mdl_txn(1, 1'b0, 32'h8, 32'h0, 4'hF, bad, ed);
    total++;
    if (n !== 4 || ga !== 1'b1 || gd !== ed) $display("FAIL lat3_read: cycles=%0d ack=%b dat=%h, required 4/1/%h", n, ga, gd, ed);
    else passed++;
    start_write8();
    cyc[1] = 1'b0; stb[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      seen |= ack[1] | err[1];
    end
    total++;
    if (seen !== 1'b0) $display("FAIL abort_resp: response seen=%b, required 0", seen);
    else passed++;
    do_txn(1, 1'b0, 32'h8, 32'h0, 4'hF, n, ga, ge, x, gd);
    mdl_txn(1, 1'b0, 32'h8, 32'h0, 4'hF, bad, ed);
    total++;
    if (ga !== 1'b1 || gd !== ed) $display("FAIL abort_keep: ack=%b dat=%h, required 1/%h", ga, gd, ed);
    else passed++;
    start_write8();
    #2 rst = 1'b0;
    #1;
    total++;
    if ({ack[1], err[1], rdat[1]} !== 34'd0)
      $display("FAIL async_reset: ack=%b err=%b dat=%h, required 0/0/0", ack[1], err[1], rdat[1]);
    else passed++;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) last[k] = 32'd0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      seen |= ack[1] | err[1];
    end
    total++;
    if (seen !== 1'b0) $display("FAIL reset_resp: response seen=%b, required 0", seen);
    else passed++;
    do_txn(1, 1'b0, 32'h8, 32'h0, 4'hF, n, ga, ge, x, gd);
    mdl_txn(1, 1'b0, 32'h8, 32'h0, 4'hF, bad, ed);
    total++;
    if (ga !== 1'b1 || gd !== ed) $display("FAIL reset_keep: ack=%b dat=%h, required 1/%h", ga, gd, ed);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n, idx, cnum; logic ga, ge, x, bad, prev, dbl; logic [31:0] gd, ed;
    for (int i = 0; i < 4; i++) begin
      gd = $urandom;
      do_txn(2, 1'b1, 32'(4 * i), gd, 4'hF, n, ga, ge, x, ed);
      mdl_txn(2, 1'b1, 32'(4 * i), gd, 4'hF, bad, ed);
    end
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; sel[2] = 4'hF; addr[2] = 32'h0;
    idx = 0; cnum = 0; prev = 1'b0; dbl = 1'b0;
    while (idx < 4 && cnum < 20) begin
      @(posedge clk); @(negedge clk);
      cnum++;
      dbl |= prev & ack[2];
      prev = ack[2];
      if (ack[2]) begin
        mdl_txn(2, 1'b0, 32'(4 * idx), 32'h0, 4'hF, bad, ed);
        total++;
        if (cnum !== 2 * idx + 1 || rdat[2] !== ed)
          $display("FAIL b2b_read%0d: cycle=%0d dat=%h, required %0d/%h", idx, cnum, rdat[2], 2 * idx + 1, ed);
        else passed++;
        idx++;
        addr[2] = 32'(4 * idx);
        if (idx == 4) begin cyc[2] = 1'b0; stb[2] = 1'b0; end
      end
    end
    cyc[2] = 1'b0; stb[2] = 1'b0;
    @(posedge clk); @(negedge clk);
    dbl |= prev & ack[2];
    total++;
    if (idx !== 4 || dbl !== 1'b0) $display("FAIL b2b_stream: acks=%0d consecutive=%b, required 4/0", idx, dbl);
    else passed++;
  endtask

  task automatic test_random();
    int n, r; logic ga, ge, x, bad, w; logic [31:0] gd, ed, a, d; logic [3:0] s;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        d = $urandom;
        do_txn(k, 1'b1, 32'h100 + 32'(4 * i), d, 4'hF, n, ga, ge, x, gd);
        mdl_txn(k, 1'b1, 32'h100 + 32'(4 * i), d, 4'hF, bad, ed);
      end
      for (int t = 0; t < 30; t++) begin
        r = int'($urandom_range(0, 9));
        a = r == 0 ? 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 63))
          : r == 1 ? 32'hFFFFFFFC | 32'($urandom_range(0, 3))
          : 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        d = $urandom; s = 4'($urandom_range(0, 15)); w = 1'($urandom_range(0, 1));
        do_txn(k, w, a, d, s, n, ga, ge, x, gd);
        mdl_txn(k, w, a, d, s, bad, ed);
        total++;
        if (n !== lat_of(k) + 1 || ga !== !bad || ge !== bad || x !== 1'b0)
          $display("FAIL rand_resp dut%0d a=%h s=%h we=%b: cycles=%0d ack=%b err=%b extra=%b, required %0d/%b/%b/0",
                   k, a, s, w, n, ga, ge, x, lat_of(k) + 1, !bad, bad);
        else passed++;
        total++;
        if (gd !== ed) $display("FAIL rand_data dut%0d a=%h s=%h we=%b: dat=%h, required %h", k, a, s, w, gd, ed);
        else passed++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cyc = 3'b0; stb = 3'b0; we = 3'b0;
    for (int k = 0; k < 3; k++) begin addr[k] = 32'h0; wdat[k] = 32'h0; sel[k] = 4'h0; end
    @(negedge clk);
    test_reset();
    test_word_rw();
    test_byte_lane();
    test_errors();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
